// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/load sequencer: button conditioning, start value
// selection, tick gating and terminal-count handling for the BCD counter.
module stopwatch_ctrl #(
   parameter int unsigned DEB_CYCLES  = 16,
   parameter int unsigned BLINK_TICKS = 50
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        tick,
   input  logic        P,
   input  logic [1:0]  sel,
   input  logic [7:0]  load,
   input  logic        at_limit,
   output logic        cnt_load,
   output logic [15:0] load_val,
   output logic        cnt_up,
   output logic        cnt_en,
   output logic        running,
   output logic        done,
   output logic        blink
);

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_RUN,
      S_PAUSE,
      S_DONE
   } state_e;

   state_e      state_q, state_d;
   logic        p_s1_q, p_s2_q;
   logic        deb_q, deb_d, deb_d1_q;
   logic [15:0] deb_cnt_q, deb_cnt_d;
   logic        p_evt_q;
   logic [1:0]  sel_q;
   logic        cnt_load_q;
   logic [15:0] load_val_q, load_val_d;
   logic        cnt_up_q;
   logic        running_q, done_q;
   logic        blink_q, blink_d;
   logic [15:0] blink_cnt_q, blink_cnt_d;

   function automatic logic [3:0] clamp9(input logic [3:0] n);
      return (n > 4'd9) ? 4'd9 : n;
   endfunction

   // Counter holds the number of consecutive cycles the synced level
   // has disagreed with the accepted level; any agreement clears it.
   always_comb begin
      deb_d     = deb_q;
      deb_cnt_d = '0;
      if (p_s2_q != deb_q) begin
         if (deb_cnt_q == 16'(DEB_CYCLES - 1)) begin
            deb_d = p_s2_q;
         end else begin
            deb_cnt_d = deb_cnt_q + 16'd1;
         end
      end
   end

   always_comb begin
      load_val_d = '0;
      unique case (sel)
         2'b00:   load_val_d = 16'h0000;
         2'b01:   load_val_d = {clamp9(load[7:4]), clamp9(load[3:0]), 8'h00};
         2'b10:   load_val_d = 16'h9999;
         default: load_val_d = {clamp9(load[7:4]), clamp9(load[3:0]), 8'h00};
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_INIT: state_d = S_IDLE;
         S_IDLE: begin
            if (sel != sel_q) begin
               state_d = S_INIT;
            end else if (p_evt_q) begin
               state_d = at_limit ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (at_limit) begin
               state_d = S_DONE;
            end else if (p_evt_q) begin
               state_d = S_PAUSE;
            end
         end
         S_PAUSE: if (p_evt_q) state_d = S_RUN;
         S_DONE:  if (p_evt_q) state_d = S_INIT;
         default: state_d = S_INIT;
      endcase
   end

   // Blink starts high on entry and flips every BLINK_TICKS ticks.
   always_comb begin
      blink_d     = 1'b0;
      blink_cnt_d = '0;
      if (state_d == S_PAUSE) begin
         if (state_q != S_PAUSE) begin
            blink_d = 1'b1;
         end else begin
            blink_d     = blink_q;
            blink_cnt_d = blink_cnt_q;
            if (tick) begin
               if (blink_cnt_q == 16'(BLINK_TICKS - 1)) begin
                  blink_d     = ~blink_q;
                  blink_cnt_d = '0;
               end else begin
                  blink_cnt_d = blink_cnt_q + 16'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         p_s1_q    <= 1'b0;
         p_s2_q    <= 1'b0;
         deb_q     <= 1'b0;
         deb_d1_q  <= 1'b0;
         deb_cnt_q <= '0;
         p_evt_q   <= 1'b0;
      end else begin
         p_s1_q    <= P;
         p_s2_q    <= p_s1_q;
         deb_q     <= deb_d;
         deb_d1_q  <= deb_q;
         deb_cnt_q <= deb_cnt_d;
         p_evt_q   <= deb_q & ~deb_d1_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_INIT;
         sel_q       <= '0;
         cnt_load_q  <= 1'b0;
         load_val_q  <= '0;
         cnt_up_q    <= 1'b0;
         running_q   <= 1'b0;
         done_q      <= 1'b0;
         blink_q     <= 1'b0;
         blink_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_load_q  <= (state_q == S_INIT);
         running_q   <= (state_d == S_RUN);
         done_q      <= (state_d == S_DONE);
         blink_q     <= blink_d;
         blink_cnt_q <= blink_cnt_d;
         if (state_q == S_INIT) begin
            sel_q      <= sel;
            load_val_q <= load_val_d;
            cnt_up_q   <= ~sel[1];
         end
      end
   end

   assign cnt_en   = (state_q == S_RUN) & tick & ~at_limit;
   assign cnt_load = cnt_load_q;
   assign load_val = load_val_q;
   assign cnt_up   = cnt_up_q;
   assign running  = running_q;
   assign done     = done_q;
   assign blink    = blink_q;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Run/pause/load sequencer for the stopwatch's 4-digit BCD counter datapath (SS.hh, range 00.00-99.99). It conditions the raw pause/start button, selects and loads the start value and count direction from the mode select, gates the 100 Hz tick into the counter, and detects terminal count. It sits between the clock divider (tick source) and the counter/display block, replacing the ad-hoc control in the state machine.

Parameters:
DEB_CYCLES, 16, consecutive stable clk cycles required to accept a new button level (1..65535)
BLINK_TICKS, 50, tick pulses per half-period of the pause blink output

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
tick  input  1  one-clk-wide pulse at 100 Hz from the clock divider
P  input  1  raw pause/start button, asynchronous, active-high
sel  input  2  mode: 00 up from 00.00, 01 up from load.00, 10 down from 99.99, 11 down from load.00
load  input  8  start seconds as two BCD digits {tens, units}
at_limit  input  1  datapath flag: counter at 99.99 (up) or 00.00 (down)
cnt_load  output  1  one-cycle strobe: counter takes load_val
load_val  output  16  BCD start value {s_tens, s_units, h_tens, h_units}
cnt_up  output  1  count direction, 1 = up
cnt_en  output  1  counter advance enable, one clk wide
running  output  1  high in RUN
done  output  1  high in DONE
blink  output  1  pause indicator for the decimal point

Behaviour:
- Reset (reset_n low, async): state INIT; all outputs 0; sync/debounce regs 0; blink counter 0. Outputs are registered except cnt_en.
- Button path: 2-FF synchronizer. Debounced level changes only after the synced level has differed from it for DEB_CYCLES consecutive clks; the counter restarts on any bounce. p_evt is a 1-clk pulse on the debounced rising edge. Release edges are ignored.
- sel and load are sampled only in INIT.
- load clamp: each nibble > 9 is replaced by 9.
- load_val by sel: 00 -> 0x0000; 01 -> {clamp(load), 8'h00}; 10 -> 0x9999; 11 -> {clamp(load), 8'h00}.
- cnt_up = ~sel[1], latched in INIT.
- INIT (1 cycle): drive load_val, cnt_up and cnt_load = 1, then go to IDLE.
- IDLE:
  - sel differs from the latched value -> INIT (reload).
  - p_evt with at_limit = 1 -> DONE.
  - p_evt otherwise -> RUN.
- RUN:
  - cnt_en = tick & ~at_limit (combinational, same cycle as tick).
  - at_limit -> DONE next edge; this has priority over a simultaneous p_evt.
  - p_evt -> PAUSE.
  - sel changes are ignored.
- PAUSE:
  - cnt_en = 0.
  - blink toggles after every BLINK_TICKS tick pulses, starting high on entry.
  - p_evt -> RUN, and blink returns to 0.
  - sel changes are ignored.
- DONE: cnt_en = 0; done = 1; p_evt -> INIT (restart with current sel/load).
- Latency:
  - Stable press -> p_evt: DEB_CYCLES + 3 clk.
  - p_evt -> state change: next edge.
  - First cnt_en: on the first tick after entering RUN.
- Tick held high multiple cycles: each clk counts. The source guarantees 1-clk pulses; this is not checked.
- reset_n asserted mid-RUN: immediate return to INIT values; counter reload on the first cycle after release.

Test Plan:
- Reset release, sel=00 -> cnt_load pulses 1 cycle, load_val=0x0000, cnt_up=1, cnt_en=0, state IDLE.
- sel=01, load=0x3C -> load_val=0x3900, cnt_up=1. Clamp check: sel=11, load=0xA5 -> load_val=0x9500, cnt_up=0.
- Bounce: P toggles every 5 clk for 60 clk, then stays high with DEB_CYCLES=16 -> exactly one p_evt, 19 clk after the last transition; RUN entered; subsequent ticks produce cnt_en pulses aligned with tick.
- RUN, press again -> PAUSE. With BLINK_TICKS=2, blink = 1,1,0,0,1 across 5 ticks and cnt_en stays 0. Press -> RUN, blink=0.
- RUN with at_limit and p_evt asserted in the same cycle -> DONE, done=1, no cnt_en. Next press -> INIT, cnt_load pulse.
- sel=11, load=0x00 (counter shows 00.00, at_limit=1), press -> DONE directly with no cnt_en. Change sel in IDLE -> reload; change sel in RUN -> no effect.
